// File: rtl/dsm_pkg.sv
// Shared types and constants for the first-order delta-sigma modulator.
package dsm_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dsm_mod1_if.sv
// Sample input handshake for dsm_mod1: the source drives data/valid, the modulator returns ready.
interface dsm_mod1_if #(
  parameter int W = 16
);

  logic [W-1:0] s_data;
  logic         s_valid;
  logic         s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/dsm_mod1_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) supplying a dither carry-in bit, one advance per step.
module dsm_lfsr
  import dsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic step,
  output logic dither
);

  logic [15:0] lfsr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
    end else if (step) begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  assign dither = lfsr[0];

endmodule

// File: rtl/dsm_mod1.sv
// First-order delta-sigma modulator: W-bit unsigned PCM in, 1-bit stream out, OSR steps per sample.
// Define DSM_DITHER_EN to feed an LFSR dither bit into the accumulator carry-in.
module dsm_mod1
  import dsm_pkg::*;
#(
  parameter int W   = 16,
  parameter int OSR = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  dsm_mod1_if.slave  s,
  output logic       bit_out,
  output logic       bit_valid,
  output logic       frame_start,
  output logic       underrun
);

  localparam int            CW       = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(OSR - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  acc;
  logic [W-1:0]  cur;
  logic          loaded;
  logic          cin;
  logic          cnt_last;
  logic          accept;
  logic          step;
  logic [W:0]    sum;

  assign cnt_last  = (cnt == CNT_LAST);
  assign s.s_ready = en && ((state == IDLE) || cnt_last);
  assign accept    = s.s_valid && s.s_ready;
  assign step      = en && (state == RUN);
  assign sum       = {1'b0, acc} + {1'b0, cur} + {{W{1'b0}}, cin};

`ifdef DSM_DITHER_EN
  logic dither;

  dsm_lfsr u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .step   (step),
    .dither (dither)
  );

  assign cin = dither;
`else
  assign cin = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Once running the modulator never idles: a missing sample just replays the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      cur         <= '0;
      cnt         <= '0;
      loaded      <= 1'b0;
      bit_out     <= 1'b0;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (en) begin
        case (state)
          IDLE: begin
            if (accept) begin
              cur    <= s.s_data;
              cnt    <= '0;
              acc    <= '0;
              loaded <= 1'b1;
            end
          end
          RUN: begin
            acc         <= sum[W-1:0];
            bit_out     <= sum[W];
            bit_valid   <= 1'b1;
            frame_start <= loaded && (cnt == '0);
            loaded      <= 1'b0;
            cnt         <= cnt_last ? '0 : cnt + 1'b1;
            if (cnt_last) begin
              if (accept) begin
                cur    <= s.s_data;
                loaded <= 1'b1;
              end else begin
                underrun <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
